mem_resp_stage: RTL



---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_resp_stage_load_extract.sv | 64 ++++++
 rtl/mem_resp_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the memory-response stage and its helpers.
//   mem_size_e      : access size encoding (B/H/W/D) with MEM_SIZE_* members
//   MEM_DEST_W      : GPR destination index width
//   MEM_MD_FWD_W(dw): width of the M->decode forwarding bus (dest + busy + data)
`ifndef MEM_PKG_SV
`define MEM_PKG_SV

`define MEM_MD_FWD_W(dw) (5 + 1 + (dw))

package mem_pkg;

  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'd0,
    MEM_SIZE_H = 2'd1,
    MEM_SIZE_W = 2'd2,
    MEM_SIZE_D = 2'd3
  } mem_size_e;

  localparam int MEM_DEST_W = 5;

endpackage

`endif

// File: rtl/mem_resp_stage_load_extract.sv
// load_extract
// Combinational lane select and zero/sign extension of SRAM read data.
//   rdata       : raw SRAM read data (DATA_W)
//   size        : access size, mem_size_e encoding
//   is_unsigned : zero-extend when set, sign-extend otherwise
//   addr_lo     : low address bits selecting the lane
//   value       : extended load value (DATA_W)
module load_extract
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]           rdata,
  input  logic [1:0]                  size,
  input  logic                        is_unsigned,
  input  logic [$clog2(DATA_W/8)-1:0] addr_lo,
  output logic [DATA_W-1:0]           value
);

  localparam int AW = $clog2(DATA_W/8);

  logic [AW-1:0]     off;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              sign;

  // Align the byte offset down to the access size, shift the lane to bit 0,
  // then mask and optionally fill the upper bits with the sign.
  always_comb begin
    off  = addr_lo;
    mask = '1;
    sign = 1'b0;
    case (mem_size_e'(size))
      MEM_SIZE_B: off = addr_lo;
      MEM_SIZE_H: off = addr_lo & ~AW'(1);
      MEM_SIZE_W: off = addr_lo & ~AW'(3);
      default:    off = '0;
    endcase
    shifted = rdata >> {off, 3'b000};
    case (mem_size_e'(size))
      MEM_SIZE_B: begin
        mask = DATA_W'(8'hFF);
        sign = shifted[7];
      end
      MEM_SIZE_H: begin
        mask = DATA_W'(16'hFFFF);
        sign = shifted[15];
      end
      MEM_SIZE_W: begin
        mask = DATA_W'(32'hFFFF_FFFF);
        sign = shifted[31];
      end
      default: begin
        mask = '1;
        sign = 1'b0;
      end
    endcase
    value = shifted & mask;
    if (!is_unsigned && sign) begin
      value = value | ~mask;
    end
  end

endmodule

// File: rtl/mem_resp_stage.sv
// mem_resp_stage
// EX->WB memory stage: holds one instruction, waits for an asynchronous SRAM
// read response, buffers it while WB stalls, extracts/extends load data and
// drives the decode forwarding bus. Stale responses after a flush are dropped
// by a discard counter.
//   clk, rst (async, active-high)
//   em_*      : instruction fields from EX, em_valid / m_allowin handshake
//   flush     : exception/ertn flush
//   data_ok, data_rdata : SRAM read response
//   w_allowin / mw_valid, mw_* : handshake and fields toward WB
//   fwd_dest, fwd_data, fwd_busy : forwarding/interlock toward decode
module mem_resp_stage
  import mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PAY_W     = 160,
  parameter int MAX_OUTST = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        em_valid,
  output logic                        m_allowin,
  input  logic [PAY_W-1:0]            em_payload,
  input  logic                        em_gr_we,
  input  logic [MEM_DEST_W-1:0]       em_dest,
  input  logic [DATA_W-1:0]           em_rf_wdata,
  input  logic                        em_load,
  input  logic [1:0]                  em_size,
  input  logic                        em_unsigned,
  input  logic [$clog2(DATA_W/8)-1:0] em_addr_lo,
  input  logic                        em_req_sent,
  input  logic                        flush,
  input  logic                        data_ok,
  input  logic [DATA_W-1:0]           data_rdata,
  input  logic                        w_allowin,
  output logic                        mw_valid,
  output logic [PAY_W-1:0]            mw_payload,
  output logic                        mw_gr_we,
  output logic [MEM_DEST_W-1:0]       mw_dest,
  output logic [DATA_W-1:0]           mw_result,
  output logic [MEM_DEST_W-1:0]       fwd_dest,
  output logic [DATA_W-1:0]           fwd_data,
  output logic                        fwd_busy
);

  localparam int AW    = $clog2(DATA_W/8);
  localparam int CNT_W = $clog2(MAX_OUTST+1);
  localparam int SUM_W = CNT_W + 2;

  logic                  m_valid;
  logic [PAY_W-1:0]      m_payload;
  logic                  m_gr_we;
  logic [MEM_DEST_W-1:0] m_dest;
  logic [DATA_W-1:0]     m_rf_wdata;
  logic                  m_load;
  logic [1:0]            m_size;
  logic                  m_unsigned;
  logic [AW-1:0]         m_addr_lo;
  logic                  m_req_sent;
  logic                  resp_got;
  logic [DATA_W-1:0]     rbuf;
  logic [CNT_W-1:0]      disc_cnt;

  logic                  wait_resp;
  logic                  data_ok_own;
  logic                  ready_go;
  logic [DATA_W-1:0]     load_data;
  logic [DATA_W-1:0]     ext_value;
  logic                  inc_wait;
  logic                  inc_ex;
  logic                  dec_disc;
  logic [SUM_W-1:0]      disc_sum;

  // A response only belongs to this entry once every stale response queued
  // ahead of it has been discarded.
  assign wait_resp   = m_valid && m_req_sent;
  assign data_ok_own = data_ok && (disc_cnt == '0);
  assign ready_go    = !wait_resp || resp_got || data_ok_own;
  assign m_allowin   = !m_valid || (ready_go && w_allowin);
  assign mw_valid    = m_valid && ready_go;

  assign load_data = resp_got ? rbuf : data_rdata;

  load_extract #(
    .DATA_W(DATA_W)
  ) u_load_extract (
    .rdata      (load_data),
    .size       (m_size),
    .is_unsigned(m_unsigned),
    .addr_lo    (m_addr_lo),
    .value      (ext_value)
  );

  assign mw_payload = m_payload;
  assign mw_gr_we   = m_gr_we;
  assign mw_dest    = m_dest;
  assign mw_result  = m_load ? ext_value : m_rf_wdata;

  assign fwd_dest = (m_valid && m_gr_we) ? m_dest : '0;
  assign fwd_busy = m_valid && m_load && !ready_go;
  assign fwd_data = mw_result;

  // Instruction slot. Flush also zeroes the payload fields so mw_* and
  // fwd_data return to their idle values rather than showing a dead entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_payload  <= '0;
      m_gr_we    <= 1'b0;
      m_dest     <= '0;
      m_rf_wdata <= '0;
      m_load     <= 1'b0;
      m_size     <= '0;
      m_unsigned <= 1'b0;
      m_addr_lo  <= '0;
      m_req_sent <= 1'b0;
      resp_got   <= 1'b0;
      rbuf       <= '0;
    end else if (flush) begin
      m_valid    <= 1'b0;
      m_payload  <= '0;
      m_gr_we    <= 1'b0;
      m_dest     <= '0;
      m_rf_wdata <= '0;
      m_load     <= 1'b0;
      m_req_sent <= 1'b0;
      resp_got   <= 1'b0;
    end else if (m_allowin) begin
      m_valid  <= em_valid;
      resp_got <= 1'b0;
      if (em_valid) begin
        m_payload  <= em_payload;
        m_gr_we    <= em_gr_we;
        m_dest     <= em_dest;
        m_rf_wdata <= em_rf_wdata;
        m_load     <= em_load;
        m_size     <= em_size;
        m_unsigned <= em_unsigned;
        m_addr_lo  <= em_addr_lo;
        m_req_sent <= em_req_sent;
      end
    end else if (wait_resp && !resp_got && data_ok_own) begin
      resp_got <= 1'b1;
      rbuf     <= data_rdata;
    end
  end

  // Discard counter: a flush orphans the response M is still waiting for
  // and any request EX already sent; each later data_ok retires one orphan.
  assign inc_wait = flush && wait_resp && !resp_got && !data_ok_own;
  assign inc_ex   = flush && em_valid && em_req_sent;
  assign dec_disc = data_ok && (disc_cnt != '0);
  assign disc_sum = SUM_W'(disc_cnt) + SUM_W'(inc_wait) + SUM_W'(inc_ex)
                  - SUM_W'(dec_disc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disc_cnt <= '0;
    end else begin
      disc_cnt <= disc_sum[CNT_W-1:0];
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    disc_sum <= SUM_W'(MAX_OUTST));

endmodule
